pmod_input_unit: RTL and testbench

//  Input side of the PMOD board interface: samples BTN_COUNT raw push-buttons from the PMOD header,

---
 rtl/pmod_input_unit_pkg.sv | 30 +++
 rtl/pmod_input_unit_debouncer.sv | 160 ++++++++++++++++
 rtl/pmod_input_unit.sv | 104 ++++++++++
 tb/tb_pmod_input_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pmod_input_unit_pkg.sv
// -----------------------------------------------------------------------------
// pmod_input_unit_pkg
//  Definitions shared by the PMOD input unit and its per-button debouncer:
//  the debounce FSM state encodings, the default tick constants, and the IAGC
//  status codes that the LED output unit also uses.
// -----------------------------------------------------------------------------
package pmod_input_unit_pkg;

    // Debounce FSM states. The encoding is fixed so that other units (and
    // debug probes) can decode it: bit 1 = settled level, bit 0 = waiting.
    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } deb_state_t;

    localparam int DEFAULT_DEBOUNCE_TICKS   = 100;
    localparam int DEFAULT_LONG_PRESS_TICKS = 5000;

    // IAGC core status codes shared with the LED output unit.
    typedef enum logic [2:0] {
        IAGC_STATUS_IDLE  = 3'd0,
        IAGC_STATUS_BUSY  = 3'd1,
        IAGC_STATUS_OK    = 3'd2,
        IAGC_STATUS_WARN  = 3'd3,
        IAGC_STATUS_ERROR = 3'd4
    } iagc_status_t;

endpackage

// File: rtl/pmod_input_unit_debouncer.sv
// -----------------------------------------------------------------------------
// pmod_input_unit_debouncer
//  One button: 2-flop synchroniser, 4-state debounce FSM with a stability
//  counter, registered level and press/release pulses, and (when the
//  PMOD_LONG_PRESS_EN macro is defined) a hold counter that raises a single
//  long-press pulse LONG_PRESS_TICKS cycles after the press pulse.
// Ports
//  i_clock    system clock
//  i_nReset   asynchronous active-low reset
//  i_raw      raw asynchronous button pin (1 = pressed)
//  o_level    debounced level
//  o_press    1-cycle pulse on committed 0->1
//  o_release  1-cycle pulse on committed 1->0
//  o_long     1-cycle long-press pulse (0 without PMOD_LONG_PRESS_EN)
// -----------------------------------------------------------------------------
module pmod_input_unit_debouncer
    import pmod_input_unit_pkg::*;
#(
    parameter int DEBOUNCE_TICKS   = DEFAULT_DEBOUNCE_TICKS,
    parameter int LONG_PRESS_TICKS = DEFAULT_LONG_PRESS_TICKS
) (
    input  logic i_clock,
    input  logic i_nReset,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    localparam int CNT_W = (DEBOUNCE_TICKS > 2) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    logic [1:0]       sync_reg;
    logic             s;
    deb_state_t       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             level_reg;
    logic             press_reg;
    logic             release_reg;

    always_ff @(posedge i_clock or negedge i_nReset) begin
        if (!i_nReset) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], i_raw};
        end
    end

    assign s = sync_reg[1];

    // The counter already holds 1 on the first cycle of WAIT_x, so the commit
    // lands DEBOUNCE_TICKS cycles after s first shows the new level.
    always_ff @(posedge i_clock or negedge i_nReset) begin
        if (!i_nReset) begin
            state_reg   <= IDLE_LO;
            cnt_reg     <= '0;
            level_reg   <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
        end else begin
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            case (state_reg)
                IDLE_LO: begin
                    if (s) begin
                        state_reg <= WAIT_HI;
                        cnt_reg   <= CNT_W'(1);
                    end
                end
                WAIT_HI: begin
                    if (!s) begin
                        state_reg <= IDLE_LO;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg <= IDLE_HI;
                        cnt_reg   <= '0;
                        level_reg <= 1'b1;
                        press_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                IDLE_HI: begin
                    if (!s) begin
                        state_reg <= WAIT_LO;
                        cnt_reg   <= CNT_W'(1);
                    end
                end
                WAIT_LO: begin
                    if (s) begin
                        state_reg <= IDLE_HI;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg   <= IDLE_LO;
                        cnt_reg     <= '0;
                        level_reg   <= 1'b0;
                        release_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE_LO;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign o_level   = level_reg;
    assign o_press   = press_reg;
    assign o_release = release_reg;

`ifdef PMOD_LONG_PRESS_EN
    localparam int HOLD_W = $clog2(LONG_PRESS_TICKS + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_TICKS - 1);

    logic [HOLD_W-1:0] hold_cnt_reg;
    logic              hold_active_reg;
    logic              long_reg;

    // The hold counter starts at 1 in the cycle the press pulse is visible,
    // so the long pulse appears LONG_PRESS_TICKS cycles after the press pulse.
    // It disarms after firing, so a continued hold never repeats the pulse.
    always_ff @(posedge i_clock or negedge i_nReset) begin
        if (!i_nReset) begin
            hold_cnt_reg    <= '0;
            hold_active_reg <= 1'b0;
            long_reg        <= 1'b0;
        end else begin
            long_reg <= 1'b0;
            if (release_reg || !level_reg) begin
                hold_cnt_reg    <= '0;
                hold_active_reg <= 1'b0;
            end else if (press_reg) begin
                hold_cnt_reg    <= HOLD_W'(1);
                hold_active_reg <= 1'b1;
            end else if (hold_active_reg) begin
                if (hold_cnt_reg == HOLD_LAST) begin
                    long_reg        <= 1'b1;
                    hold_active_reg <= 1'b0;
                    hold_cnt_reg    <= '0;
                end else begin
                    hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
                end
            end
        end
    end

    assign o_long = long_reg;
`else
    // Hold counter compiled out; the parameter is still referenced here so the
    // port-compatible instance stays warning-free.
    logic unused_long_cfg;
    assign unused_long_cfg = (LONG_PRESS_TICKS != 0);
    assign o_long = 1'b0;
`endif

endmodule

// File: rtl/pmod_input_unit.sv
// -----------------------------------------------------------------------------
// pmod_input_unit
//  Input side of the PMOD board interface. Each raw button is synchronised and
//  debounced by its own pmod_input_unit_debouncer; committed presses are turned
//  into a one-at-a-time command stream (valid/ready) for the IAGC control core.
//  Optional feature macro: PMOD_LONG_PRESS_EN (per-button long-press pulse).
// Ports
//  i_clock        system clock
//  i_nReset       asynchronous active-low reset
//  i_btn_raw      raw bouncing button pins (1 = pressed)
//  o_btn_level    debounced level per button
//  o_btn_press    1-cycle pulse on committed 0->1
//  o_btn_release  1-cycle pulse on committed 1->0
//  o_btn_long     1-cycle long-press pulse (0 without PMOD_LONG_PRESS_EN)
//  o_cmd_valid    a command is pending
//  o_cmd          index of the lowest pending button
//  i_cmd_ready    consumer accepts the command this cycle
//  o_cmd_drop     1-cycle pulse: press merged into an already-pending command
// -----------------------------------------------------------------------------
module pmod_input_unit
    import pmod_input_unit_pkg::*;
#(
    parameter int BTN_COUNT        = 4,
    parameter int CMD_WIDTH        = 3,
    parameter int DEBOUNCE_TICKS   = DEFAULT_DEBOUNCE_TICKS,
    parameter int LONG_PRESS_TICKS = DEFAULT_LONG_PRESS_TICKS
) (
    input  logic                 i_clock,
    input  logic                 i_nReset,
    input  logic [BTN_COUNT-1:0] i_btn_raw,
    output logic [BTN_COUNT-1:0] o_btn_level,
    output logic [BTN_COUNT-1:0] o_btn_press,
    output logic [BTN_COUNT-1:0] o_btn_release,
    output logic [BTN_COUNT-1:0] o_btn_long,
    output logic                 o_cmd_valid,
    output logic [CMD_WIDTH-1:0] o_cmd,
    input  logic                 i_cmd_ready,
    output logic                 o_cmd_drop
);

    logic [BTN_COUNT-1:0] press_vec;
    logic [BTN_COUNT-1:0] pending_reg;
    logic [BTN_COUNT-1:0] pending_next;
    logic [BTN_COUNT-1:0] accept_mask;
    logic [CMD_WIDTH-1:0] cmd_sel;
    logic                 drop_reg;
    logic                 drop_next;

    generate
        for (genvar gi = 0; gi < BTN_COUNT; gi++) begin : g_btn
            pmod_input_unit_debouncer #(
                .DEBOUNCE_TICKS   (DEBOUNCE_TICKS),
                .LONG_PRESS_TICKS (LONG_PRESS_TICKS)
            ) u_debouncer (
                .i_clock   (i_clock),
                .i_nReset  (i_nReset),
                .i_raw     (i_btn_raw[gi]),
                .o_level   (o_btn_level[gi]),
                .o_press   (press_vec[gi]),
                .o_release (o_btn_release[gi]),
                .o_long    (o_btn_long[gi])
            );
        end
    endgenerate

    assign o_btn_press = press_vec;

    // Priority select: lowest set index wins. Depends only on registered
    // state, so o_cmd is stable while the consumer stalls.
    always_comb begin
        cmd_sel = '0;
        for (int i = BTN_COUNT - 1; i >= 0; i--) begin
            if (pending_reg[i]) begin
                cmd_sel = CMD_WIDTH'(i);
            end
        end
    end

    // Accepting clears the presented (lowest) bit; a press on that same button
    // in the same cycle re-arms it as a fresh command rather than a drop.
    always_comb begin
        accept_mask = '0;
        if (i_cmd_ready) begin
            accept_mask = pending_reg & (~pending_reg + BTN_COUNT'(1));
        end
        pending_next = (pending_reg & ~accept_mask) | press_vec;
        drop_next    = |(press_vec & pending_reg & ~accept_mask);
    end

    always_ff @(posedge i_clock or negedge i_nReset) begin
        if (!i_nReset) begin
            pending_reg <= '0;
            drop_reg    <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            drop_reg    <= drop_next;
        end
    end

    assign o_cmd_valid = |pending_reg;
    assign o_cmd       = cmd_sel;
    assign o_cmd_drop  = drop_reg;

endmodule

// File: tb/tb_pmod_input_unit.sv
module tb_pmod_input_unit;

    localparam int BTN = 4;
    localparam int CW  = 3;

`ifdef PMOD_LONG_PRESS_EN
    localparam int EXP_LONG_COUNT = 1;
`else
    localparam int EXP_LONG_COUNT = 0;
`endif

    logic           clk;
    logic           n_reset;
    logic [BTN-1:0] btn_raw;
    logic [BTN-1:0] btn_level;
    logic [BTN-1:0] btn_press;
    logic [BTN-1:0] btn_release;
    logic [BTN-1:0] btn_long;
    logic           cmd_valid;
    logic [CW-1:0]  cmd;
    logic           cmd_ready;
    logic           cmd_drop;

    int checks   = 0;
    int failures = 0;

    pmod_input_unit #(
        .BTN_COUNT        (BTN),
        .CMD_WIDTH        (CW),
        .DEBOUNCE_TICKS   (8),
        .LONG_PRESS_TICKS (40)
    ) dut (
        .i_clock       (clk),
        .i_nReset      (n_reset),
        .i_btn_raw     (btn_raw),
        .o_btn_level   (btn_level),
        .o_btn_press   (btn_press),
        .o_btn_release (btn_release),
        .o_btn_long    (btn_long),
        .o_cmd_valid   (cmd_valid),
        .o_cmd         (cmd),
        .i_cmd_ready   (cmd_ready),
        .o_cmd_drop    (cmd_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_level"}, 32'(btn_level), 32'h0);
        check({tag, "_press"}, 32'(btn_press), 32'h0);
        check({tag, "_release"}, 32'(btn_release), 32'h0);
        check({tag, "_long"}, 32'(btn_long), 32'h0);
        check({tag, "_valid"}, 32'(cmd_valid), 32'h0);
        check({tag, "_drop"}, 32'(cmd_drop), 32'h0);
    endtask

    int press_cnt;
    int press_at;
    int drop_cnt;
    int long_cnt;
    int long_at;

    initial begin
        n_reset   = 1'b0;
        btn_raw   = '0;
        cmd_ready = 1'b1;
        tick_n(3);
        check_all_zero("reset");
        n_reset = 1'b1;
        tick_n(2);

        // 1. Clean press on btn0: level/pulse after exactly 10 edges.
        btn_raw[0] = 1'b1;
        tick_n(9);
        check("t1_level_at9", 32'(btn_level), 32'h0);
        tick();
        check("t1_level_at10", 32'(btn_level), 32'h1);
        check("t1_press_at10", 32'(btn_press), 32'h1);
        tick();
        check("t1_press_gone", 32'(btn_press), 32'h0);
        check("t1_valid", 32'(cmd_valid), 32'h1);
        check("t1_cmd", 32'(cmd), 32'h0);
        tick();
        check("t1_valid_cleared", 32'(cmd_valid), 32'h0);
        btn_raw[0] = 1'b0;
        tick_n(10);
        check("t1_release_pulse", 32'(btn_release), 32'h1);
        check("t1_level_low", 32'(btn_level), 32'h0);
        tick_n(3);
        $display("tb: txn1 clean press btn0 done");

        // 2. Bounce on btn1: 10 segments of 3 cycles, then a steady 1.
        press_cnt = 0;
        press_at  = -1;
        for (int seg = 0; seg < 10; seg++) begin
            btn_raw[1] = (seg % 2 == 0);
            for (int c = 0; c < 3; c++) begin
                tick();
                if (btn_press[1]) press_cnt++;
            end
        end
        btn_raw[1] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (btn_press[1]) begin
                press_cnt++;
                press_at = k;
            end
        end
        check("t2_press_count", 32'(press_cnt), 32'd1);
        check("t2_press_delay", 32'(press_at), 32'd10);
        check("t2_level", 32'(btn_level), 32'h2);
        btn_raw[1] = 1'b0;
        tick_n(14);
        $display("tb: txn2 bounce btn1 press_count=%0d at=%0d", press_cnt, press_at);

        // 3. btn0 and btn2 together, consumer stalled 5 cycles.
        cmd_ready  = 1'b0;
        btn_raw[0] = 1'b1;
        btn_raw[2] = 1'b1;
        tick_n(10);
        check("t3_press_both", 32'(btn_press), 32'h5);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t3_stall_valid", 32'(cmd_valid), 32'h1);
            check("t3_stall_cmd", 32'(cmd), 32'h0);
            tick();
        end
        cmd_ready = 1'b1;
        check("t3_first_cmd", 32'(cmd), 32'h0);
        tick();
        check("t3_second_valid", 32'(cmd_valid), 32'h1);
        check("t3_second_cmd", 32'(cmd), 32'h2);
        tick();
        check("t3_done_valid", 32'(cmd_valid), 32'h0);
        btn_raw = '0;
        tick_n(14);
        $display("tb: txn3 simultaneous btn0/btn2 served in order");

        // 4. Second btn3 press while its command is still pending.
        cmd_ready  = 1'b0;
        btn_raw[3] = 1'b1;
        tick_n(11);
        check("t4_valid", 32'(cmd_valid), 32'h1);
        check("t4_cmd", 32'(cmd), 32'h3);
        btn_raw[3] = 1'b0;
        tick_n(12);
        drop_cnt   = 0;
        btn_raw[3] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (cmd_drop) drop_cnt++;
            if (k == 11) check("t4_drop_at11", 32'(cmd_drop), 32'h1);
        end
        check("t4_drop_count", 32'(drop_cnt), 32'd1);
        cmd_ready = 1'b1;
        check("t4_deliver_cmd", 32'(cmd), 32'h3);
        tick();
        check("t4_single_delivery", 32'(cmd_valid), 32'h0);
        btn_raw[3] = 1'b0;
        tick_n(14);
        $display("tb: txn4 repeat press btn3 drops=%0d", drop_cnt);

        // 5. Reset mid-handshake (btn2 pending) and mid-debounce (btn1 WAIT_HI).
        cmd_ready  = 1'b0;
        btn_raw[2] = 1'b1;
        tick_n(11);
        check("t5_pending", 32'(cmd_valid), 32'h1);
        btn_raw[1] = 1'b1;
        tick_n(5);
        n_reset = 1'b0;
        btn_raw = '0;
        #1;
        check_all_zero("t5_async");
        tick_n(2);
        n_reset   = 1'b1;
        press_cnt = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (btn_press != 0 || cmd_valid) press_cnt++;
        end
        check("t5_no_activity", 32'(press_cnt), 32'd0);
        $display("tb: txn5 reset mid-flight activity=%0d", press_cnt);

        // 6. Long press on btn0 held 60 cycles past commit.
        cmd_ready  = 1'b1;
        btn_raw[0] = 1'b1;
        tick_n(10);
        check("t6_press", 32'(btn_press), 32'h1);
        long_cnt = 0;
        long_at  = -1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (btn_long[0]) begin
                long_cnt++;
                long_at = k;
            end
        end
        check("t6_long_count", 32'(long_cnt), 32'(EXP_LONG_COUNT));
`ifdef PMOD_LONG_PRESS_EN
        check("t6_long_delay", 32'(long_at), 32'd40);
`endif
        btn_raw[0] = 1'b0;
        tick_n(12);
        $display("tb: txn6 long press count=%0d at=%0d", long_cnt, long_at);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
